toeplitz_wordbuf: RTL



---
 rtl/toeplitz_pkg.sv | 17 +
 rtl/toeplitz_blkmem.sv | 28 ++
 rtl/toeplitz_wordbuf.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/toeplitz_pkg.sv
// Shared definitions for the Toeplitz extractor datapath: default widths, block/word types
// and a small index-width helper used by the extractor, the serializer and the word buffer.
package toeplitz_pkg;

    localparam int unsigned BS_DEFAULT = 64;
    localparam int unsigned L_DEFAULT  = 128;
    localparam int unsigned W          = L_DEFAULT / BS_DEFAULT;

    typedef logic [BS_DEFAULT-1:0] word_t;
    typedef logic [L_DEFAULT-1:0]  block_t;

    // Width of an index that ranges over 0..n-1; never narrower than one bit.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/toeplitz_blkmem.sv
// DEPTH x L register file: one synchronous write port, one asynchronous block-wide read port.
// Contents are not reset; validity is tracked by the owner's pointers.
module toeplitz_blkmem
    import toeplitz_pkg::*;
#(
    parameter int unsigned L     = L_DEFAULT,
    parameter int unsigned DEPTH = 4,
    parameter int unsigned AW    = idx_width(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [L-1:0]  wdata,
    input  logic [AW-1:0] raddr,
    output logic [L-1:0]  rdata
);

    logic [L-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/toeplitz_wordbuf.sv
// Block-capturing output buffer for the Toeplitz extractor: queues up to DEPTH L-bit blocks and
// drains them MS word first over valid/ready. Define TOEPLITZ_OVF_CNT_EN to add ovf_cnt.
module toeplitz_wordbuf
    import toeplitz_pkg::*;
#(
    parameter int unsigned BS    = BS_DEFAULT,
    parameter int unsigned L     = L_DEFAULT,
    parameter int unsigned DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [L-1:0]               q,
    input  logic                       qstrobe,
    output logic [BS-1:0]              dout,
    output logic                       dvalid,
    input  logic                       dready,
    output logic [$clog2(DEPTH+1)-1:0] level,
`ifdef TOEPLITZ_OVF_CNT_EN
    output logic                       ovf,
    output logic [15:0]                ovf_cnt
`else
    output logic                       ovf
`endif
);

    localparam int unsigned NUM_WORDS = L / BS;
    localparam int unsigned AW        = idx_width(DEPTH);
    localparam int unsigned IW        = idx_width(NUM_WORDS);
    localparam int unsigned LW        = $clog2(DEPTH + 1);

    logic [AW-1:0] wp_q, wp_d;
    logic [AW-1:0] rp_q, rp_d;
    logic [IW-1:0] widx_q, widx_d;
    logic [LW-1:0] level_q, level_d;
    logic          ovf_q, ovf_d;

    logic          not_empty;
    logic          pop;
    logic          last_pop;
    logic          full;
    logic          accept;
    logic          drop;
    logic [L-1:0]  rd_block;

    toeplitz_blkmem #(
        .L     (L),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_blkmem (
        .clk   (clk),
        .we    (accept),
        .waddr (wp_q),
        .wdata (q),
        .raddr (rp_q),
        .rdata (rd_block)
    );

    always_comb begin
        not_empty = (level_q != '0);
        pop       = not_empty && dready;
        last_pop  = pop && (widx_q == IW'(NUM_WORDS - 1));
        full      = (level_q == LW'(DEPTH));
        // A full buffer still takes the block if its head slot frees up this same cycle.
        accept    = qstrobe && (!full || last_pop);
        drop      = qstrobe && !accept;
    end

    always_comb begin
        wp_d    = wp_q;
        rp_d    = rp_q;
        widx_d  = widx_q;
        level_d = level_q;
        ovf_d   = ovf_q | drop;

        if (accept) begin
            wp_d = wp_q + AW'(1);
        end

        if (pop) begin
            if (last_pop) begin
                widx_d = '0;
                rp_d   = rp_q + AW'(1);
            end else begin
                widx_d = widx_q + IW'(1);
            end
        end

        unique case ({accept, last_pop})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wp_q    <= '0;
            rp_q    <= '0;
            widx_q  <= '0;
            level_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            wp_q    <= wp_d;
            rp_q    <= rp_d;
            widx_q  <= widx_d;
            level_q <= level_d;
            ovf_q   <= ovf_d;
        end
    end

`ifdef TOEPLITZ_OVF_CNT_EN
    logic [15:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (drop && (cnt_q != 16'hFFFF)) begin
            cnt_d = cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign ovf_cnt = cnt_q;
`endif

    // Word 0 is the most-significant slice of the head block.
    always_comb begin
        dout = '0;
        for (int unsigned i = 0; i < NUM_WORDS; i++) begin
            if (widx_q == IW'(i)) begin
                dout = rd_block[L-1-i*BS -: BS];
            end
        end
    end

    assign dvalid = not_empty;
    assign level  = level_q;
    assign ovf    = ovf_q;

endmodule
